countdown_timer_bcd: RTL and testbench

Two-digit BCD down-counter with load, start, pause and terminal-count detection; the counting complement of the lab's free-running up-counter. Counts a preset value down to 00 at a rate set by an internal prescaler, then raises a one-cycle done pulse and holds an expired flag. Sits between the front-panel controls (debounced load/start/pause pulses) and the seven-segment decoders that display the two digits.

---
 rtl/countdown_timer_bcd_if.sv | 24 ++
 rtl/countdown_timer_bcd.sv | 115 +++++++++++
 tb/tb_countdown_timer_bcd.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_bcd_if.sv
// Front-panel control and display bundle for the two-digit BCD countdown timer.
// The master drives load/start/pause and presets; the slave returns digits and status.
interface countdown_timer_bcd_if;
  logic       load;
  logic [3:0] init_tens;
  logic [3:0] init_ones;
  logic       start;
  logic       pause;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       done;
  logic       expired;

  modport master (
    output load, init_tens, init_ones, start, pause,
    input  tens, ones, running, done, expired
  );

  modport slave (
    input  load, init_tens, init_ones, start, pause,
    output tens, ones, running, done, expired
  );
endinterface

// File: rtl/countdown_timer_bcd.sv
// Two-digit BCD down-counter: load/start/pause control, prescaled stepping,
// one-cycle done pulse on reaching 00 and a held expired flag.
module countdown_timer_bcd #(
  parameter int TICK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  resetN,
  countdown_timer_bcd_if.slave  bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_tens, w_tens_nxt;
  logic [3:0]    r_ones, w_ones_nxt;
  logic [PW-1:0] r_pre, w_pre_nxt;
  logic          r_done, w_done_nxt;
  logic          w_advance;
  logic [7:0]    w_step;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // One decrement with borrow; 00 stays 00 so the count can never wrap.
  function automatic logic [7:0] bcd_dec(input logic [3:0] t, input logic [3:0] o);
    if (t == 4'd0 && o == 4'd0) return 8'h00;
    if (o != 4'd0)              return {t, o - 4'd1};
    return {t - 4'd1, 4'd9};
  endfunction

  assign w_step = bcd_dec(r_tens, r_ones);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= IDLE;
      r_tens  <= 4'd0;
      r_ones  <= 4'd0;
      r_pre   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tens  <= w_tens_nxt;
      r_ones  <= w_ones_nxt;
      r_pre   <= w_pre_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tens_nxt  = r_tens;
    w_ones_nxt  = r_ones;
    w_pre_nxt   = r_pre;
    w_done_nxt  = 1'b0;
    w_advance   = 1'b0;

    if (bus.load) begin
      w_state_nxt = IDLE;
      w_pre_nxt   = '0;
      w_tens_nxt  = clamp_bcd(bus.init_tens);
      w_ones_nxt  = clamp_bcd(bus.init_ones);
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (r_tens == 4'd0 && r_ones == 4'd0) begin
              w_state_nxt = DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = RUN;
              w_pre_nxt   = '0;
            end
          end
        end
        RUN: begin
          if (bus.pause) w_state_nxt = PAUSE;
          else           w_advance   = 1'b1;
        end
        // The resume edge counts, so a pause from P to R costs exactly R-P cycles.
        PAUSE: begin
          if (bus.start) begin
            w_state_nxt = RUN;
            w_advance   = 1'b1;
          end
        end
        default: ;
      endcase

      if (w_advance) begin
        if (r_pre == PRE_TOP) begin
          w_pre_nxt  = '0;
          w_tens_nxt = w_step[7:4];
          w_ones_nxt = w_step[3:0];
          if (w_step == 8'h00) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_pre_nxt = r_pre + 1'b1;
        end
      end
    end
  end

  assign bus.tens    = r_tens;
  assign bus.ones    = r_ones;
  assign bus.running = (r_state == RUN);
  assign bus.expired = (r_state == DONE);
  assign bus.done    = r_done;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Bench for countdown_timer_bcd: two instances (TICK_DIV 4 and 1) share stimulus and
// are checked every cycle against a decimal-count reference model plus literal pins.
module tb_countdown_timer_bcd;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  typedef struct packed {
    int   mode;
    int   count;
    int   acc;
    logic done;
  } model_t;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       load = 1'b0;
  logic [3:0] init_tens = 4'd0;
  logic [3:0] init_ones = 4'd0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       chk_en = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  model_t m4, m1;

  always #5 clk = ~clk;

  countdown_timer_bcd_if if4();
  countdown_timer_bcd_if if1();

  assign if4.load = load;      assign if1.load = load;
  assign if4.init_tens = init_tens; assign if1.init_tens = init_tens;
  assign if4.init_ones = init_ones; assign if1.init_ones = init_ones;
  assign if4.start = start;    assign if1.start = start;
  assign if4.pause = pause;    assign if1.pause = pause;

  countdown_timer_bcd #(.TICK_DIV(4)) dut4 (.clk(clk), .resetN(resetN), .bus(if4));
  countdown_timer_bcd #(.TICK_DIV(1)) dut1 (.clk(clk), .resetN(resetN), .bus(if1));

  // Reference: count kept as a decimal integer; acc counts active edges since the last step.
  function automatic model_t mstep(model_t m, int td, logic ld, int it, int io, logic st, logic pa);
    model_t n;
    bit adv;
    n = m;
    n.done = 1'b0;
    adv = 1'b0;
    if (ld) begin
      n.mode  = M_IDLE;
      n.acc   = 0;
      n.count = ((it > 9) ? 9 : it) * 10 + ((io > 9) ? 9 : io);
    end else begin
      case (m.mode)
        M_IDLE: if (st) begin
          if (m.count == 0) begin n.mode = M_DONE; n.done = 1'b1; end
          else begin n.mode = M_RUN; n.acc = 0; end
        end
        M_RUN:   if (pa) n.mode = M_PAUSE; else adv = 1'b1;
        M_PAUSE: if (st) begin n.mode = M_RUN; adv = 1'b1; end
        default: ;
      endcase
      if (adv) begin
        n.acc = n.acc + 1;
        if (n.acc == td) begin
          n.acc = 0;
          n.count = n.count - 1;
          if (n.count == 0) begin n.mode = M_DONE; n.done = 1'b1; end
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m4 <= '{M_IDLE, 0, 0, 1'b0};
      m1 <= '{M_IDLE, 0, 0, 1'b0};
    end else begin
      m4 <= mstep(m4, 4, load, int'(init_tens), int'(init_ones), start, pause);
      m1 <= mstep(m1, 1, load, int'(init_tens), int'(init_ones), start, pause);
    end
  end

  task automatic chk_lit(string nm, int which, int et, int eo, bit er, bit ed, bit ee);
    logic [10:0] got, exp;
    if (which == 4) got = {if4.tens, if4.ones, if4.running, if4.done, if4.expired};
    else            got = {if1.tens, if1.ones, if1.running, if1.done, if1.expired};
    exp = {4'(et), 4'(eo), er, ed, ee};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got tens/ones/run/done/exp=%h/%h/%b/%b/%b expected %h/%h/%b/%b/%b",
               nm, got[10:7], got[6:3], got[2], got[1], got[0],
               exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic chk_model(string nm, int which, model_t m);
    chk_lit(nm, which, m.count / 10, m.count % 10, m.mode == M_RUN, m.done, m.mode == M_DONE);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk_model("model_td4", 4, m4);
      chk_model("model_td1", 1, m1);
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(int t, int o);
    load = 1'b1; init_tens = 4'(t); init_ones = 4'(o);
    tick(1);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Pulls reset low between edges and checks outputs before any clock edge arrives.
  task automatic async_reset(string nm);
    #2 resetN = 1'b0;
    #1;
    chk_lit(nm, 4, 0, 0, 0, 0, 0);
    chk_lit(nm, 1, 0, 0, 0, 0, 0);
    tick(1);
    resetN = 1'b1;
  endtask

  initial begin
    tick(2);
    resetN = 1'b1;
    chk_en = 1'b1;
    chk_lit("reset_state", 4, 0, 0, 0, 0, 0);

    // Full countdown from 12 at TICK_DIV=4
    do_load(1, 2);
    do_start();
    chk_lit("cd_start", 4, 1, 2, 1, 0, 0);
    tick(4);  chk_lit("cd_first_step", 4, 1, 1, 1, 0, 0);
    tick(8);  chk_lit("cd_borrow", 4, 0, 9, 1, 0, 0);
    tick(36); chk_lit("cd_expire", 4, 0, 0, 0, 1, 1);
    tick(1);  chk_lit("cd_done_drop", 4, 0, 0, 0, 0, 1);

    // TICK_DIV=1 from 03
    do_load(0, 3);
    do_start();
    chk_lit("td1_start", 1, 0, 3, 1, 0, 0);
    tick(1); chk_lit("td1_02", 1, 0, 2, 1, 0, 0);
    tick(1); chk_lit("td1_01", 1, 0, 1, 1, 0, 0);
    tick(1); chk_lit("td1_00", 1, 0, 0, 0, 1, 1);
    tick(1); chk_lit("td1_done_drop", 1, 0, 0, 0, 0, 1);

    // Pause two cycles after start, resume ten cycles later
    do_load(0, 5);
    do_start();
    tick(1); pause = 1'b1;
    tick(1); pause = 1'b0;
    tick(9); start = 1'b1;
    tick(1); start = 1'b0;
    chk_lit("pause_resume_e12", 4, 0, 5, 1, 0, 0);
    tick(1); chk_lit("pause_resume_e13", 4, 0, 5, 1, 0, 0);
    tick(1); chk_lit("pause_resume_e14", 4, 0, 4, 1, 0, 0);

    // pause+start while running: pause wins
    pause = 1'b1; start = 1'b1;
    tick(1);
    pause = 1'b0; start = 1'b0;
    chk_lit("pause_over_start", 4, 0, 4, 0, 0, 0);
    tick(5); chk_lit("paused_hold", 4, 0, 4, 0, 0, 0);

    // load+start together: load wins, start is lost
    start = 1'b1;
    do_load(3, 7);
    start = 1'b0;
    chk_lit("load_over_start", 4, 3, 7, 0, 0, 0);
    tick(3); chk_lit("load_over_start_hold", 4, 3, 7, 0, 0, 0);

    do_load(15, 10);
    chk_lit("clamp_td4", 4, 9, 9, 0, 0, 0);
    chk_lit("clamp_td1", 1, 9, 9, 0, 0, 0);

    // Start from 00 goes straight to DONE with a pulse; start/pause then ignored
    do_load(0, 0);
    do_start();
    chk_lit("zero_start", 4, 0, 0, 0, 1, 1);
    tick(1); chk_lit("zero_done_drop", 4, 0, 0, 0, 0, 1);
    start = 1'b1; pause = 1'b1;
    tick(1);
    start = 1'b0; pause = 1'b0;
    chk_lit("start_in_done", 4, 0, 0, 0, 0, 1);

    // Reload while running at 07
    do_load(0, 9);
    do_start();
    tick(8); chk_lit("reload_at_07", 4, 0, 7, 1, 0, 0);
    do_load(2, 0);
    chk_lit("reload_20", 4, 2, 0, 0, 0, 0);
    do_start();
    tick(3); chk_lit("restart_full_delay", 4, 2, 0, 1, 0, 0);
    tick(1); chk_lit("restart_first_step", 4, 1, 9, 1, 0, 0);

    // Asynchronous reset mid-run
    do_load(5, 0);
    do_start();
    tick(3);
    async_reset("async_reset");
    tick(2); chk_lit("post_reset_idle", 4, 0, 0, 0, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      load      = ($urandom_range(0, 299) == 0);
      init_tens = 4'($urandom_range(0, 15));
      init_ones = 4'($urandom_range(0, 15));
      start     = ($urandom_range(0, 9) == 0);
      pause     = ($urandom_range(0, 24) == 0);
      tick(1);
      if ($urandom_range(0, 1499) == 0) begin
        load = 1'b0; start = 1'b0; pause = 1'b0;
        async_reset("rand_async_reset");
      end
    end
    load = 1'b0; start = 1'b0; pause = 1'b0;
    tick(2);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
